addsub_ctrl: RTL

//   Sequencing stage that sits directly upstream of the 3-bit add/subtract unit.
//   - Holds a small operand register file and decodes one instruction at a time.
//   - Drives the adder's A, B and Ci inputs, captures its S and Co outputs, then writes the result back.
//   - Together with the adder it forms the datapath/control pair of the simple processor.
//

---
 rtl/addsub_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/addsub_ctrl.sv
// Control stage for a combinational add/sub unit: a small register file, a 4-state
// sequencer (IDLE/T1/T2/T3) and C/Z flags captured from the adder outputs.
module addsub_ctrl #(
    parameter int WIDTH = 3,
    parameter int NREG  = 4
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Run,
    input  logic [1:0]               Op,
    input  logic [$clog2(NREG)-1:0]  Rx,
    input  logic [$clog2(NREG)-1:0]  Ry,
    input  logic [WIDTH-1:0]         Imm,
    output logic [WIDTH-1:0]         A,
    output logic [WIDTH-1:0]         B,
    output logic                     Ci,
    input  logic [WIDTH-1:0]         S,
    input  logic                     Co,
    output logic                     Busy,
    output logic                     Done,
    output logic                     CFlag,
    output logic                     ZFlag,
    input  logic [$clog2(NREG)-1:0]  RdSel,
    output logic [WIDTH-1:0]         RdData
);
    localparam int RSEL = $clog2(NREG);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;
    localparam logic [1:0] T3   = 2'd3;

    logic [1:0]                  state;
    logic [1:0]                  op_q;
    logic [RSEL-1:0]             rx_q;
    logic [RSEL-1:0]             ry_q;
    logic [WIDTH-1:0]            imm_q;
    logic [WIDTH-1:0]            a_reg;
    logic [WIDTH-1:0]            g_reg;
    logic [NREG-1:0][WIDTH-1:0]  regs;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            op_q  <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
            imm_q <= '0;
            a_reg <= '0;
            g_reg <= '0;
            regs  <= '0;
            CFlag <= 1'b0;
            ZFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        op_q  <= Op;
                        rx_q  <= Rx;
                        ry_q  <= Ry;
                        imm_q <= Imm;
                        state <= T1;
                    end
                end
                T1: begin
                    if (!op_q[1]) begin
                        regs[rx_q] <= op_q[0] ? imm_q : regs[ry_q];
                        state      <= IDLE;
                    end else begin
                        a_reg <= regs[rx_q];
                        state <= T2;
                    end
                end
                T2: begin
                    g_reg <= S;
                    CFlag <= Co;
                    ZFlag <= (S == '0);
                    state <= T3;
                end
                default: begin
                    regs[rx_q] <= g_reg;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Adder inputs are only non-zero while the sum is being sampled in T2.
    assign A      = (state == T2) ? a_reg      : '0;
    assign B      = (state == T2) ? regs[ry_q] : '0;
    assign Ci     = (state == T2) ? op_q[0]    : 1'b0;
    assign Busy   = (state != IDLE);
    assign Done   = (state == T3) || ((state == T1) && !op_q[1]);
    assign RdData = regs[RdSel];

endmodule
